// File: rtl/out_cmd_driver.sv
// out_cmd_driver: sequences key bus (outP) and data bus (out) toward the output CPLD.
// Data only changes while the key reads KEY_IDLE, so the CPLD never sees a data edge
// framed by a valid key. A watchdog drops to the safe pattern if refreshes stop.
//
// Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both
// 1; cmd_arm/cmd_data are captured on that edge. cmd_ready is a registered function of the
// state only (1 in IDLE and HOLDING). The controller holds cmd_valid until the transfer;
// cmd_valid while cmd_ready=0 has no effect.
module out_cmd_driver #(
  parameter int               N_OUT     = 28,
  parameter int               N_KEY     = 8,
  parameter logic [1:N_KEY]   KEY_IDLE  = 8'b11111000,
  parameter logic [1:N_KEY]   KEY_ARM   = 8'b11110101,
  parameter int               SETUP_CYC = 4,
  parameter int               HOLD_CYC  = 16,
  parameter int               GAP_CYC   = 4,
  parameter int               WDOG_CYC  = 500000
) (
  input  logic             pclk_50M,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_arm,
  input  logic [1:N_OUT]   cmd_data,
  output logic [1:N_KEY]   outP,
  output logic [1:N_OUT]   out,
  output logic             busy,
  output logic             wdog_trip,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ARM     = 3'd2,
    S_HOLDING = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(SETUP_CYC + HOLD_CYC + GAP_CYC + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [19:0]      WDOG_LAST  = 20'(WDOG_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;       // phase length counter for SETUP/ARM/GAP
  logic [19:0]      wdog;      // cycles in HOLDING since ARM entry or last refresh
  logic [1:N_OUT]   pend;      // data waiting behind the GAP phase
  logic             pend_arm;  // 1: GAP leads to SETUP with pend, 0: GAP leads to IDLE
  logic             acc;

  assign acc       = cmd_valid & cmd_ready;
  assign state_dbg = state;

  // Sequencer: state, phase counters and all registered outputs.
  always_ff @(posedge pclk_50M or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      outP      <= KEY_IDLE;
      out       <= '1;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      wdog_trip <= 1'b0;
      cnt       <= '0;
      wdog      <= '0;
      pend      <= '1;
      pend_arm  <= 1'b0;
    end else begin
      // Any accepted arm command acknowledges a previous watchdog trip.
      if (acc && cmd_arm) wdog_trip <= 1'b0;

      case (state)
        S_IDLE: begin
          outP      <= KEY_IDLE;
          out       <= '1;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (acc && cmd_arm) begin
            state     <= S_SETUP;
            out       <= cmd_data;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            cnt       <= '0;
          end
        end

        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state <= S_ARM;
            outP  <= KEY_ARM;
            cnt   <= '0;
            wdog  <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_ARM: begin
          if (cnt == HOLD_LAST) begin
            state     <= S_HOLDING;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_HOLDING: begin
          if (acc) begin
            if (cmd_arm && (cmd_data == out)) begin
              // Refresh with unchanged data: only the watchdog restarts.
              wdog <= '0;
            end else begin
              // Drop the key first; data stays put for the whole GAP.
              state     <= S_GAP;
              outP      <= KEY_IDLE;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              cnt       <= '0;
              pend      <= cmd_data;
              pend_arm  <= cmd_arm;
            end
          end else if (wdog == WDOG_LAST) begin
            // Controller went silent: force the safe pattern at once.
            state     <= S_IDLE;
            outP      <= KEY_IDLE;
            out       <= '1;
            wdog_trip <= 1'b1;
          end else if (wdog != '1) begin
            wdog <= wdog + 20'd1;
          end
        end

        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (pend_arm) begin
              state <= S_SETUP;
              out   <= pend;
            end else begin
              state     <= S_IDLE;
              out       <= '1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state     <= S_IDLE;
          outP      <= KEY_IDLE;
          out       <= '1;
          cmd_ready <= 1'b0;
          busy      <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_cmd_driver.sv
// Bench for out_cmd_driver: directed vector table, hand-written watchdog/reset
// sequences and random commands checked every cycle against a timeline model.
module tb_out_cmd_driver;

  localparam int         WD     = 64;
  localparam logic [1:8]  K_IDLE = 8'b11111000;
  localparam logic [1:8]  K_ARM  = 8'b11110101;
  localparam logic [1:28] ALL1   = 28'hfffffff;
  localparam logic [1:28] D1     = 28'b1111111100000000000001101000;
  localparam logic [1:28] D2     = 28'b1111111100000001000001101000;

  // ---------------- clock / reset ----------------
  logic        pclk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_arm = 1'b0;
  logic [1:28] cmd_data = ALL1;
  logic [1:8]  outP;
  logic [1:28] out;
  logic        busy;
  logic        wdog_trip;
  logic [2:0]  state_dbg;

  always #10 pclk_50M = ~pclk_50M;

  out_cmd_driver #(.WDOG_CYC(WD)) dut (
    .pclk_50M (pclk_50M),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_arm  (cmd_arm),
    .cmd_data (cmd_data),
    .outP     (outP),
    .out      (out),
    .busy     (busy),
    .wdog_trip(wdog_trip),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected behaviour as a timeline: each accepted command appends the cycles it
  // implies (gap, setup, arm hold); when the timeline is empty the driver rests in
  // either idle or holding.
  typedef struct packed {
    logic [1:8]  key;
    logic [1:28] dat;
    logic        rdy;
    logic        bsy;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        cur;
  logic        m_hold;
  logic [1:28] m_data;
  int          m_wd;
  logic        m_trip;
  logic        m_trip_edge;
  logic [1:8]  prev_key;
  logic [1:28] prev_out;

  task automatic push_n(input int n, input logic [1:8] k, input logic [1:28] d);
    for (int i = 0; i < n; i++) exp_q.push_back('{key: k, dat: d, rdy: 1'b0, bsy: 1'b1});
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur    = '{key: K_IDLE, dat: ALL1, rdy: 1'b0, bsy: 1'b0};
    m_hold = 1'b0;
    m_data = ALL1;
    m_wd   = 0;
    m_trip = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic a, input logic [1:28] d);
    logic acc;
    acc = v && cur.rdy;
    m_trip_edge = 1'b0;
    if (acc) begin
      if (a) m_trip = 1'b0;
      if (!m_hold) begin
        if (a) begin
          push_n(4, K_IDLE, d);
          push_n(16, K_ARM, d);
          m_hold = 1'b1; m_data = d; m_wd = 0;
        end
      end else if (a && d == m_data) begin
        m_wd = 0;
      end else begin
        push_n(4, K_IDLE, m_data);
        if (a) begin
          push_n(4, K_IDLE, d);
          push_n(16, K_ARM, d);
          m_data = d; m_wd = 0;
        end else begin
          m_hold = 1'b0;
        end
      end
    end else if (m_hold && cur.rdy) begin
      m_wd++;
      if (m_wd == WD) begin
        m_hold = 1'b0; m_trip = 1'b1; m_trip_edge = 1'b1;
      end
    end
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else if (m_hold) cur = '{key: K_ARM, dat: m_data, rdy: 1'b1, bsy: 1'b0};
    else cur = '{key: K_IDLE, dat: ALL1, rdy: 1'b1, bsy: 1'b0};
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive at negedge, advance model at posedge, compare at next negedge.
  task automatic tick(input logic v, input logic a, input logic [1:28] d);
    cmd_valid = v; cmd_arm = a; cmd_data = d;
    @(posedge pclk_50M);
    model_edge(v, a, d);
    @(negedge pclk_50M);
    check("cycle", {25'b0, outP, out, cmd_ready, busy, wdog_trip}, {25'b0, cur, m_trip});
    if (out !== prev_out && !m_trip_edge)
      check("key_frame", {63'b0, (prev_key == K_IDLE && outP == K_IDLE)}, 64'd1);
    prev_key = outP;
    prev_out = out;
  endtask

  task automatic send(input logic a, input logic [1:28] d);
    logic acc;
    int   k;
    acc = 1'b0;
    k   = 0;
    while (!acc && k < 200) begin
      acc = cur.rdy;
      tick(1'b1, a, d);
      k++;
    end
    cmd_valid = 1'b0;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, ALL1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge pclk_50M);
    @(negedge pclk_50M);
    check("reset_vals", {25'b0, outP, out, cmd_ready, busy, wdog_trip},
          {25'b0, K_IDLE, ALL1, 3'b000});
    rst = 1'b0;
    model_reset();
    prev_key = outP;
    prev_out = out;
    tick(1'b0, 1'b0, ALL1);
    check("ready_after_rst", {63'b0, cmd_ready}, 64'd1);
  endtask

  // ---------------- directed vectors ----------------
  // Each row: optionally send a command, run w idle cycles, then expect key/data/ready.
  typedef struct {
    logic        snd;
    logic        arm;
    logic [1:28] dat;
    int          w;
    logic [1:8]  key;
    logic [1:28] dout;
    logic        rdy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] r32;
    logic [1:28] rd;

    tbl[0]  = '{1'b1, 1'b1, D1,   0,  K_IDLE, D1,   1'b0};  // setup cycle 1
    tbl[1]  = '{1'b0, 1'b0, ALL1, 3,  K_IDLE, D1,   1'b0};  // setup cycle 4
    tbl[2]  = '{1'b0, 1'b0, ALL1, 1,  K_ARM,  D1,   1'b0};  // first arm cycle
    tbl[3]  = '{1'b0, 1'b0, ALL1, 15, K_ARM,  D1,   1'b0};  // last arm cycle
    tbl[4]  = '{1'b0, 1'b0, ALL1, 1,  K_ARM,  D1,   1'b1};  // holding
    tbl[5]  = '{1'b1, 1'b1, D2,   0,  K_IDLE, D1,   1'b0};  // gap, old data
    tbl[6]  = '{1'b0, 1'b0, ALL1, 3,  K_IDLE, D1,   1'b0};  // last gap cycle
    tbl[7]  = '{1'b0, 1'b0, ALL1, 1,  K_IDLE, D2,   1'b0};  // setup, new data
    tbl[8]  = '{1'b0, 1'b0, ALL1, 3,  K_IDLE, D2,   1'b0};
    tbl[9]  = '{1'b0, 1'b0, ALL1, 1,  K_ARM,  D2,   1'b0};
    tbl[10] = '{1'b0, 1'b0, ALL1, 16, K_ARM,  D2,   1'b1};
    tbl[11] = '{1'b1, 1'b0, ALL1, 0,  K_IDLE, D2,   1'b0};  // safe: gap first
    tbl[12] = '{1'b0, 1'b0, ALL1, 4,  K_IDLE, ALL1, 1'b1};  // then idle
    tbl[13] = '{1'b1, 1'b0, D1,   0,  K_IDLE, ALL1, 1'b1};  // arm=0 in idle: no effect

    model_reset();
    prev_key = K_IDLE;
    prev_out = ALL1;
    @(negedge pclk_50M);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].snd) send(tbl[i].arm, tbl[i].dat);
      idle(tbl[i].w);
      check($sformatf("vec%0d", i), {27'b0, outP, out, cmd_ready},
            {27'b0, tbl[i].key, tbl[i].dout, tbl[i].rdy});
    end

    // Refresh keeps the key armed well past the watchdog period.
    send(1'b1, D1);
    idle(20);
    for (int i = 0; i < 10; i++) begin
      idle(40);
      send(1'b1, D1);
    end
    check("refresh_key", {56'b0, outP}, {56'b0, K_ARM});
    check("refresh_trip", {63'b0, wdog_trip}, 64'd0);

    // Watchdog: last accept was the refresh above; trip lands 64 edges later.
    idle(63);
    check("wdog_before", {35'b0, outP, wdog_trip}, {35'b0, K_ARM, 1'b0});
    idle(1);
    check("wdog_trip", {27'b0, outP, out, wdog_trip}, {27'b0, K_IDLE, ALL1, 1'b1});
    send(1'b1, D1);
    check("wdog_clear", {63'b0, wdog_trip}, 64'd0);

    // Asynchronous reset mid-setup: outputs fall to reset values without a clock edge.
    idle(30);
    send(1'b0, ALL1);
    idle(6);
    send(1'b1, D2);
    idle(1);
    #2 rst = 1'b1;
    #1;
    check("async_rst", {25'b0, outP, out, cmd_ready, busy, wdog_trip},
          {25'b0, K_IDLE, ALL1, 3'b000});
    @(negedge pclk_50M);
    do_reset();

    // Random commands against the model.
    for (int i = 0; i < 300; i++) begin
      int op;
      op  = $urandom_range(0, 9);
      r32 = $urandom;
      rd  = r32[27:0];
      if (op < 4)      send($urandom_range(0, 4) != 0, rd);
      else if (op < 6) send(1'b1, m_data);
      else if (op < 7) send(1'b1, ($urandom_range(0, 1) != 0) ? D1 : D2);
      else             idle($urandom_range(1, 80));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
